// File: rtl/sap1_pkg.sv
// Shared types and constants for the SAP-1 control sequencer.
package sap1_pkg;

  // Opcode values carried in the IR upper nibble
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // One-hot ring positions, bit0 = T1
  localparam logic [5:0] RING_T1 = 6'b000001;
  localparam logic [5:0] RING_T2 = 6'b000010;
  localparam logic [5:0] RING_T3 = 6'b000100;
  localparam logic [5:0] RING_T4 = 6'b001000;
  localparam logic [5:0] RING_T5 = 6'b010000;
  localparam logic [5:0] RING_T6 = 6'b100000;

  // Decoded sequencer state
  typedef enum logic [2:0] {
    T1   = 3'd0,
    T2   = 3'd1,
    T3   = 3'd2,
    T4   = 3'd3,
    T5   = 3'd4,
    T6   = 3'd5,
    HALT = 3'd6
  } tstate_e;

  // Every strobe the sequencer drives into the datapath
  typedef struct packed {
    logic pc_inc;
    logic pc_en;
    logic mar_load;
    logic ram_en;
    logic ir_load;
    logic ir_en;
    logic load_a;
    logic enable_a;
    logic load_b;
    logic add;
    logic sub;
    logic alu_en;
    logic load_out;
  } ctrl_word_t;

  // True when exactly one bit of a 6-bit ring is set; guards against a
  // corrupted ring register ever producing two overlapping T-states.
  function automatic logic is_onehot6(input logic [5:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 6; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return (cnt == 3'd1);
  endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T1..T6 ring counter with hold and synchronous reset.
import sap1_pkg::*;

module sap1_ring_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  output logic [5:0] ring
);

  logic [5:0] ring_r;

  // Rotate one position per enabled edge; an illegal pattern restarts at T1
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_r <= RING_T1;
    end else if (!is_onehot6(ring_r)) begin
      ring_r <= RING_T1;
    end else if (advance) begin
      ring_r <= {ring_r[4:0], ring_r[5]};
    end else begin
      ring_r <= ring_r;
    end
  end

  assign ring = ring_r;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: ring counter plus opcode decode of all strobes.
import sap1_pkg::*;

module sap1_controller #(
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  output logic           pc_inc,
  output logic           pc_en,
  output logic           mar_load,
  output logic           ram_en,
  output logic           ir_load,
  output logic           ir_en,
  output logic           load_a,
  output logic           enable_a,
  output logic           load_b,
  output logic           add,
  output logic           sub,
  output logic           alu_en,
  output logic           load_out,
  output logic           halted,
  output logic [5:0]     tstate
);

  logic [5:0] ring_s;
  logic       halted_r;
  logic       halted_nxt_s;
  logic       advance_s;
  tstate_e    state_s;
  ctrl_word_t ctrl_s;
  logic [5:0] tstate_s;

  sap1_ring_counter u_ring (
    .clk     (clk),
    .rst     (rst),
    .advance (advance_s),
    .ring    (ring_s)
  );

  // Halt flag register: only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_r <= 1'b0;
    end else begin
      halted_r <= halted_nxt_s;
    end
  end

  // Map ring position plus halt flag onto the symbolic state
  always_comb begin
    state_s = T1;
    if (halted_r) begin
      state_s = HALT;
    end else begin
      case (ring_s)
        RING_T1: state_s = T1;
        RING_T2: state_s = T2;
        RING_T3: state_s = T3;
        RING_T4: state_s = T4;
        RING_T5: state_s = T5;
        RING_T6: state_s = T6;
        default: state_s = T1;
      endcase
    end
  end

  // Next-state logic: advance the ring when running, divert T4 of HLT into HALT
  always_comb begin
    halted_nxt_s = halted_r;
    advance_s    = 1'b0;
    if (rst) begin
      halted_nxt_s = 1'b0;
      advance_s    = 1'b0;
    end else if (halted_r) begin
      halted_nxt_s = 1'b1;
      advance_s    = 1'b0;
    end else if (run) begin
      if ((state_s == T4) && (opcode == OPW'(OP_HLT))) begin
        halted_nxt_s = 1'b1;
        advance_s    = 1'b0;
      end else begin
        halted_nxt_s = 1'b0;
        advance_s    = 1'b1;
      end
    end else begin
      halted_nxt_s = 1'b0;
      advance_s    = 1'b0;
    end
  end

  // Strobe decode; paused, reset or halted cycles drive nothing onto the bus
  always_comb begin
    ctrl_s = '0;
    if (rst || !run) begin
      ctrl_s = '0;
    end else begin
      case (state_s)
        T1: begin
          ctrl_s.pc_en    = 1'b1;
          ctrl_s.mar_load = 1'b1;
        end
        T2: begin
          ctrl_s.pc_inc = 1'b1;
        end
        T3: begin
          ctrl_s.ram_en  = 1'b1;
          ctrl_s.ir_load = 1'b1;
        end
        T4: begin
          case (opcode)
            OPW'(OP_LDA), OPW'(OP_ADD), OPW'(OP_SUB): begin
              ctrl_s.ir_en    = 1'b1;
              ctrl_s.mar_load = 1'b1;
            end
            OPW'(OP_OUT): begin
              ctrl_s.enable_a = 1'b1;
              ctrl_s.load_out = 1'b1;
            end
            default: ctrl_s = '0;
          endcase
        end
        T5: begin
          case (opcode)
            OPW'(OP_LDA): begin
              ctrl_s.ram_en = 1'b1;
              ctrl_s.load_a = 1'b1;
            end
            OPW'(OP_ADD), OPW'(OP_SUB): begin
              ctrl_s.ram_en = 1'b1;
              ctrl_s.load_b = 1'b1;
            end
            default: ctrl_s = '0;
          endcase
        end
        T6: begin
          case (opcode)
            OPW'(OP_ADD): begin
              ctrl_s.alu_en = 1'b1;
              ctrl_s.add    = 1'b1;
              ctrl_s.load_a = 1'b1;
            end
            OPW'(OP_SUB): begin
              ctrl_s.alu_en = 1'b1;
              ctrl_s.sub    = 1'b1;
              ctrl_s.load_a = 1'b1;
            end
            default: ctrl_s = '0;
          endcase
        end
        HALT:    ctrl_s = '0;
        default: ctrl_s = '0;
      endcase
    end
  end

  // Debug T-state view: T1 while reset is held, blank while halted
  always_comb begin
    tstate_s = 6'b000000;
    if (rst) begin
      tstate_s = RING_T1;
    end else if (halted_r) begin
      tstate_s = 6'b000000;
    end else begin
      tstate_s = ring_s;
    end
  end

  assign pc_inc   = ctrl_s.pc_inc;
  assign pc_en    = ctrl_s.pc_en;
  assign mar_load = ctrl_s.mar_load;
  assign ram_en   = ctrl_s.ram_en;
  assign ir_load  = ctrl_s.ir_load;
  assign ir_en    = ctrl_s.ir_en;
  assign load_a   = ctrl_s.load_a;
  assign enable_a = ctrl_s.enable_a;
  assign load_b   = ctrl_s.load_b;
  assign add      = ctrl_s.add;
  assign sub      = ctrl_s.sub;
  assign alu_en   = ctrl_s.alu_en;
  assign load_out = ctrl_s.load_out;
  assign halted   = halted_r;
  assign tstate   = tstate_s;

endmodule

// File: tb/tb_sap1_controller.sv
// Directed bench: the sequencer drives a small SAP-1 datapath running a fixed program.
module tb_sap1_controller;

  logic       clk;
  logic       rst;
  logic       run;
  logic [3:0] opcode;
  logic pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en;
  logic load_a, enable_a, load_b, add, sub, alu_en, load_out, halted;
  logic [5:0] tstate;

  int checks_s;
  int errors_s;
  logic mon_en;

  // Datapath state
  logic       dp_clr;
  logic [3:0] pc_r, mar_r;
  logic [7:0] ir_r, a_r, b_r, out_r;
  logic [7:0] ram [16];
  logic [7:0] bus_s;

  localparam logic [12:0] S_CP  = 13'h1000;
  localparam logic [12:0] S_EP  = 13'h0800;
  localparam logic [12:0] S_LM  = 13'h0400;
  localparam logic [12:0] S_CE  = 13'h0200;
  localparam logic [12:0] S_LI  = 13'h0100;
  localparam logic [12:0] S_EI  = 13'h0080;
  localparam logic [12:0] S_LA  = 13'h0040;
  localparam logic [12:0] S_EA  = 13'h0020;
  localparam logic [12:0] S_LB  = 13'h0010;
  localparam logic [12:0] S_ADD = 13'h0008;
  localparam logic [12:0] S_SUB = 13'h0004;
  localparam logic [12:0] S_EU  = 13'h0002;
  localparam logic [12:0] S_LO  = 13'h0001;
  localparam logic [12:0] S_NONE = 13'h0000;

  localparam logic [5:0] TS1 = 6'b000001;
  localparam logic [5:0] TS2 = 6'b000010;
  localparam logic [5:0] TS3 = 6'b000100;
  localparam logic [5:0] TS4 = 6'b001000;
  localparam logic [5:0] TS5 = 6'b010000;
  localparam logic [5:0] TS6 = 6'b100000;

  logic [12:0] strb_s;
  assign strb_s = {pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en, load_a,
                   enable_a, load_b, add, sub, alu_en, load_out};
  assign opcode = ir_r[7:4];

  sap1_controller #(.OPW(4)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .pc_inc(pc_inc), .pc_en(pc_en), .mar_load(mar_load), .ram_en(ram_en),
    .ir_load(ir_load), .ir_en(ir_en), .load_a(load_a), .enable_a(enable_a),
    .load_b(load_b), .add(add), .sub(sub), .alu_en(alu_en),
    .load_out(load_out), .halted(halted), .tstate(tstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus source selection
  always_comb begin
    bus_s = 8'h00;
    if (pc_en)         bus_s = {4'h0, pc_r};
    else if (ram_en)   bus_s = ram[mar_r];
    else if (ir_en)    bus_s = {4'h0, ir_r[3:0]};
    else if (enable_a) bus_s = a_r;
    else if (alu_en)   bus_s = sub ? (a_r - b_r) : (a_r + b_r);
    else               bus_s = 8'h00;
  end

  // Datapath registers acting on the edge that ends each T-state
  always @(posedge clk) begin
    if (dp_clr) begin
      pc_r <= 4'h0; mar_r <= 4'h0; ir_r <= 8'h00;
      a_r <= 8'h00; b_r <= 8'h00; out_r <= 8'h00;
    end else begin
      if (pc_inc)   pc_r  <= pc_r + 4'h1;
      if (mar_load) mar_r <= bus_s[3:0];
      if (ir_load)  ir_r  <= bus_s;
      if (load_a)   a_r   <= bus_s;
      if (load_b)   b_r   <= bus_s;
      if (load_out) out_r <= bus_s;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_s++;
    if (obs !== exp) begin
      errors_s++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus exclusivity every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      chk("bus_onehot", 32'($countones({pc_en, ram_en, ir_en, enable_a, alu_en}) <= 1), 32'd1);
      chk("add_sub_excl", 32'(add & sub), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [5:0] t, input logic [12:0] s);
    chk({tag, "_tstate"}, 32'(tstate), 32'(t));
    chk({tag, "_strobes"}, 32'(strb_s), 32'(s));
  endtask

  task automatic do_fetch(input string tag);
    chk_state({tag, "_T1"}, TS1, S_EP | S_LM); tick();
    chk_state({tag, "_T2"}, TS2, S_CP);        tick();
    chk_state({tag, "_T3"}, TS3, S_CE | S_LI); tick();
  endtask

  initial begin
    checks_s = 0;
    errors_s = 0;
    mon_en   = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    ram[0]  = 8'h09;  // LDA 9
    ram[1]  = 8'h1A;  // ADD A
    ram[2]  = 8'hE0;  // OUT
    ram[3]  = 8'h09;  // LDA 9 (paused in T5)
    ram[4]  = 8'h2A;  // SUB A
    ram[5]  = 8'hE0;  // OUT
    ram[6]  = 8'h09;  // LDA 9 (reset in T5)
    ram[7]  = 8'hF0;  // HLT
    ram[9]  = 8'h05;
    ram[10] = 8'h03;

    rst = 1'b1; run = 1'b0; dp_clr = 1'b1;
    tick();
    chk_state("rst_idle", TS1, S_NONE);
    chk("rst_halted", 32'(halted), 32'd0);
    run = 1'b1;
    #1;
    chk_state("rst_run", TS1, S_NONE);
    tick();
    rst = 1'b0; dp_clr = 1'b0; mon_en = 1'b1;
    #1;

    // LDA 9
    do_fetch("lda0");
    chk_state("lda0_T4", TS4, S_EI | S_LM); tick();
    chk_state("lda0_T5", TS5, S_CE | S_LA); tick();
    chk_state("lda0_T6", TS6, S_NONE);      tick();
    chk("lda0_a", 32'(a_r), 32'h05);

    // ADD A
    do_fetch("add");
    chk_state("add_T4", TS4, S_EI | S_LM); tick();
    chk_state("add_T5", TS5, S_CE | S_LB); tick();
    chk_state("add_T6", TS6, S_EU | S_ADD | S_LA); tick();
    chk("add_a", 32'(a_r), 32'h08);

    // OUT
    do_fetch("out0");
    chk_state("out0_T4", TS4, S_EA | S_LO); tick();
    chk("out0_reg", 32'(out_r), 32'h08);
    chk_state("out0_T5", TS5, S_NONE); tick();
    chk_state("out0_T6", TS6, S_NONE); tick();

    // LDA 9 with a three-cycle pause in T5
    do_fetch("lda1");
    chk_state("lda1_T4", TS4, S_EI | S_LM); tick();
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_state("pause_T5", TS5, S_NONE);
      tick();
    end
    chk("pause_a_held", 32'(a_r), 32'h08);
    run = 1'b1;
    #1;
    chk_state("resume_T5", TS5, S_CE | S_LA); tick();
    chk_state("resume_T6", TS6, S_NONE);
    chk("resume_a", 32'(a_r), 32'h05);
    tick();

    // SUB A
    do_fetch("sub");
    chk_state("sub_T4", TS4, S_EI | S_LM); tick();
    chk_state("sub_T5", TS5, S_CE | S_LB); tick();
    chk_state("sub_T6", TS6, S_EU | S_SUB | S_LA); tick();
    chk("sub_a", 32'(a_r), 32'h02);

    // OUT
    do_fetch("out1");
    chk_state("out1_T4", TS4, S_EA | S_LO); tick();
    chk("out1_reg", 32'(out_r), 32'h02);
    tick(); tick();

    // LDA 9 interrupted by reset in T5
    do_fetch("lda2");
    chk_state("lda2_T4", TS4, S_EI | S_LM); tick();
    rst = 1'b1;
    #1;
    chk_state("midrst_T5", TS1, S_NONE);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_a", 32'(a_r), 32'h02);

    // HLT: four enabled edges from T1 to HALT
    do_fetch("hlt");
    chk_state("hlt_T4", TS4, S_NONE);
    chk("hlt_T4_halted", 32'(halted), 32'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      run = (i >= 10) ? 1'b0 : 1'b1;
      #1;
      chk_state("halt_hold", 6'b000000, S_NONE);
      chk("halt_flag", 32'(halted), 32'd1);
      tick();
    end
    run = 1'b1;
    rst = 1'b1;
    #1;
    chk_state("halt_rst", TS1, S_NONE);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_halted", 32'(halted), 32'd0);
    chk_state("post_rst_T1", TS1, S_EP | S_LM);
    tick();
    chk_state("post_rst_T2", TS2, S_CP);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
    $finish;
  end

endmodule

// File: doc/sap1_controller.md
# sap1_controller

Control sequencer for the SAP-1 datapath. It generates every bus-enable, register-load and ALU-operation strobe that drives the A/B registers, the ALU, PC, MAR, RAM, IR and output register. A six-state ring counter (T1–T6) runs each instruction through fetch (T1–T3) and execute (T4–T6). Execute strobes are decoded from the opcode nibble held in the IR.

## Interface
Parameters:
- `OPW`, 4: opcode width (IR upper nibble).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  1 = sequencer advances; 0 = state held (single-step/pause).
- `opcode`  in  OPW  IR[7:4]; stable from T4 through T6.
- `pc_inc`  out  1  increment PC (Cp).
- `pc_en`  out  1  PC drives bus (Ep).
- `mar_load`  out  1  MAR loads from bus (Lm).
- `ram_en`  out  1  RAM drives bus (CE).
- `ir_load`  out  1  IR loads from bus (Li).
- `ir_en`  out  1  IR operand nibble drives bus (Ei).
- `load_a`  out  1  register A loads.
- `enable_a`  out  1  register A drives bus.
- `load_b`  out  1  register B loads.
- `add`  out  1  ALU add select.
- `sub`  out  1  ALU subtract select.
- `alu_en`  out  1  ALU result drives bus (Eu).
- `load_out`  out  1  output register loads.
- `halted`  out  1  sequencer stopped on HLT.
- `tstate`  out  6  one-hot T-state (bit0 = T1), for debug.

## Operation
- States: T1..T6 and HALT.
- With `run` = 1, the state advances T1→T2→…→T6→T1 on each clock. With `run` = 0, the state is held and all strobes are 0.
- Fetch (opcode ignored):
  - T1: `pc_en`, `mar_load`.
  - T2: `pc_inc`.
  - T3: `ram_en`, `ir_load`.
- Execute by opcode:
  - LDA 4'h0:
    - T4: `ir_en`, `mar_load`.
    - T5: `ram_en`, `load_a`.
    - T6: none.
  - ADD 4'h1:
    - T4: `ir_en`, `mar_load`.
    - T5: `ram_en`, `load_b`.
    - T6: `alu_en`, `add`, `load_a`.
  - SUB 4'h2: same as ADD, but T6 asserts `sub` instead of `add`.
  - OUT 4'hE:
    - T4: `enable_a`, `load_out`.
    - T5, T6: none.
  - HLT 4'hF: T4 asserts no strobes. The next edge (if `run` = 1) enters HALT.
  - Any other opcode: T4–T6 are NOP.
- HALT: all strobes 0 and `halted` = 1. HALT is left only by `rst`; `run` has no effect.
- Bus exclusivity:
  - At most one of `pc_en`, `ram_en`, `ir_en`, `enable_a`, `alu_en` is asserted in any cycle.
  - `add` and `sub` are never asserted together.

## Timing
- Strobes are combinational decodes of the registered state, `opcode` and `run`. Datapath registers act on the rising edge that ends the T-state.
- `rst` sampled high: the next state is T1 and `halted` = 0. While `rst` is high, all strobes are forced to 0 and `tstate` = 6'b000001.
- Reset mid-instruction (any T-state or HALT): the sequencer returns to T1 on the next edge. No partial execute strobes appear after that edge.
- Instruction latency is 6 enabled cycles. HLT reaches HALT 4 enabled cycles after T1.
- `run` deasserted mid-instruction:
  - The state is frozen and strobes are 0 for that cycle.
  - When `run` returns to 1, the state resumes from the same T-state and the strobe repeats.
- An `opcode` change during T1–T3 has no effect. It is sampled only in T4–T6.

## Structure
- `sap1_pkg` holds:
  - opcode constants (`OP_LDA`, `OP_ADD`, `OP_SUB`, `OP_OUT`, `OP_HLT`);
  - the `tstate_e` enum (T1..T6, HALT);
  - the `ctrl_word_t` packed struct bundling all strobes.
- Sub-module `sap1_ring_counter`: the one-hot T1–T6 counter with `run` hold and synchronous reset. The decode is in `sap1_controller`.

## Test plan
- Reset, then `run` = 1 for 3 cycles with any opcode → T1: `pc_en` = `mar_load` = 1; T2: `pc_inc` = 1; T3: `ram_en` = `ir_load` = 1; every other strobe 0.
- Opcode 4'h1 (ADD) → T4: `ir_en` + `mar_load`; T5: `ram_en` + `load_b`; T6: `alu_en` + `add` + `load_a`. With A = 8'h05 and B = 8'h03 via the datapath bench, A = 8'h08 after T6.
- Opcode 4'h2 (SUB) with A = 8'h05 and B = 8'h03 → T6 asserts `sub` and not `add`; A = 8'h02.
- Opcode 4'hF → HALT on the 4th edge after T1; `halted` = 1 and all strobes 0 for 20 further cycles; `rst` for 1 cycle → T1 and `halted` = 0.
- Set `run` = 0 in T5 for 3 cycles → `tstate` stays 6'b010000 with strobes 0; after `run` = 1, T5 strobes appear once and T6 follows.
- Assert `rst` in T5 of LDA → no `load_a` after that edge; next state T1; every cycle checked for bus-enable one-hot-or-zero.
